spi_lens_sequencer: RTL and testbench

- Transaction-level controller for SPI_driver. Serves register-access requests from two clients (focus and iris control FSMs) with a round-robin arbiter.
- Turns each request into back-to-back command and tx FIFO pushes, waits for the driver frame to finish, and pops the read byte.
- Sits between the lens control logic and SPI_driver. It is the only block that drives command_read, tx_read and rx_read.

---
 rtl/spi_lens_sequencer.sv | 176 +++++++++++++++++
 tb/tb_spi_lens_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_lens_sequencer.sv
// Round-robin transaction sequencer between the focus/iris control FSMs and SPI_driver.
// Define LENS_SEQ_TIMEOUT_EN to enable the frame timeout counter and err_o.
module spi_lens_sequencer #(
   parameter int         TIMEOUT_CYCLES = 4096,
   parameter logic [3:0] DRV_IDLE       = 4'b0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_i,
   input  logic [1:0]  rw_i,
   input  logic [13:0] addr_i,
   input  logic [15:0] wdata_i,
   output logic [1:0]  done_o,
   output logic [7:0]  rdata_o,
   output logic        err_o,
   input  logic [3:0]  drv_state_i,
   output logic        cmd_push_o,
   output logic [1:0]  cmd_rw_o,
   output logic        tx_push_o,
   output logic [7:0]  tx_byte_o,
   output logic        rx_pop_o,
   input  logic [7:0]  rx_byte_i,
   output logic [3:0]  dbg_state_o
);

   // Handshake: req_i[k] is held high until done_o[k] pulses for one cycle; every
   // push/pop strobe is a single-cycle write/read enable into the driver FIFOs.
   typedef enum logic [3:0] {
      S_INIT       = 4'd0,
      S_IDLE       = 4'd1,
      S_PUSH0      = 4'd2,
      S_PUSH1      = 4'd3,
      S_WAIT_START = 4'd4,
      S_WAIT_DONE  = 4'd5,
      S_POP        = 4'd6,
      S_CAPTURE    = 4'd7,
      S_RESP       = 4'd8
   } state_t;

   state_t      state, state_n;
   logic        ptr;
   logic        gnt;
   logic        gnt_sel;
   logic        rw_q;
   logic [6:0]  addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rdata_q;
   logic        timeout;
   logic        err_q;

   // Contention goes to the pointer; a lone requester always wins.
   assign gnt_sel = (req_i == 2'b11) ? ptr : req_i[1];

`ifdef LENS_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;

   assign timeout = (state == S_WAIT_START || state == S_WAIT_DONE) &&
                    (cnt == CNT_W'(TIMEOUT_CYCLES));

   // WAIT_START is only ever entered from PUSH1, so clearing there is clearing on entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == S_PUSH1)
            cnt <= '0;
         else if (state == S_WAIT_START || state == S_WAIT_DONE)
            cnt <= cnt + 1'b1;
         if (state == S_IDLE && req_i != 2'b00)
            err_q <= 1'b0;
         else if (timeout)
            err_q <= 1'b1;
      end
   end

   assign err_o = (state == S_RESP) && err_q;
`else
   assign timeout = 1'b0;
   assign err_q   = 1'b0;
   assign err_o   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_INIT;
         ptr     <= 1'b0;
         gnt     <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_n;
         if (state == S_IDLE && req_i != 2'b00) begin
            gnt     <= gnt_sel;
            rw_q    <= rw_i[gnt_sel];
            addr_q  <= gnt_sel ? addr_i[13:7] : addr_i[6:0];
            wdata_q <= gnt_sel ? wdata_i[15:8] : wdata_i[7:0];
         end
         if (state == S_CAPTURE)
            rdata_q <= rx_byte_i;
         // Favour whichever client was not just served.
         if (state == S_RESP)
            ptr <= ~gnt;
      end
   end

   always_comb begin
      state_n    = state;
      cmd_push_o = 1'b0;
      cmd_rw_o   = 2'b00;
      tx_push_o  = 1'b0;
      tx_byte_o  = 8'h00;
      rx_pop_o   = 1'b0;
      done_o     = 2'b00;
      case (state)
         S_INIT: begin
            if (drv_state_i == DRV_IDLE)
               state_n = S_IDLE;
         end
         S_IDLE: begin
            if (req_i != 2'b00)
               state_n = S_PUSH0;
         end
         S_PUSH0: begin
            tx_push_o  = 1'b1;
            tx_byte_o  = {rw_q, addr_q};
            cmd_push_o = 1'b1;
            cmd_rw_o   = 2'b01;
            state_n    = S_PUSH1;
         end
         S_PUSH1: begin
            cmd_push_o = 1'b1;
            if (rw_q) begin
               cmd_rw_o = 2'b10;
            end else begin
               cmd_rw_o  = 2'b01;
               tx_push_o = 1'b1;
               tx_byte_o = wdata_q;
            end
            state_n = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (timeout)
               state_n = S_RESP;
            else if (drv_state_i != DRV_IDLE)
               state_n = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (timeout)
               state_n = S_RESP;
            else if (drv_state_i == DRV_IDLE)
               state_n = rw_q ? S_POP : S_RESP;
         end
         S_POP: begin
            rx_pop_o = 1'b1;
            state_n  = S_CAPTURE;
         end
         S_CAPTURE: begin
            state_n = S_RESP;
         end
         S_RESP: begin
            done_o  = gnt ? 2'b10 : 2'b01;
            // After a timeout the driver may still be stuck, so resynchronise first.
            state_n = err_q ? S_INIT : S_IDLE;
         end
         default: state_n = S_INIT;
      endcase
   end

   assign rdata_o     = rdata_q;
   assign dbg_state_o = state;

endmodule

// File: tb/tb_spi_lens_sequencer.sv
// Directed bench for spi_lens_sequencer; the driver is modelled by driving drv_state_i by hand.
// Build with LENS_SEQ_TIMEOUT_EN to exercise the timeout path instead of the wait-forever path.
module tb_spi_lens_sequencer;

   localparam int TO = 200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_i;
   logic [1:0]  rw_i;
   logic [13:0] addr_i;
   logic [15:0] wdata_i;
   logic [1:0]  done_o;
   logic [7:0]  rdata_o;
   logic        err_o;
   logic [3:0]  drv_state_i;
   logic        cmd_push_o;
   logic [1:0]  cmd_rw_o;
   logic        tx_push_o;
   logic [7:0]  tx_byte_o;
   logic        rx_pop_o;
   logic [7:0]  rx_byte_i;
   logic [3:0]  dbg_state_o;

   int checks = 0;
   int fails  = 0;
   int cmd_cnt = 0;
   int tx_cnt = 0;
   int pop_cnt = 0;
   int done_cnt = 0;
   logic [1:0] exp_q[$];

   always #5 clk = ~clk;

   spi_lens_sequencer #(.TIMEOUT_CYCLES(TO), .DRV_IDLE(4'b0000)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .rw_i(rw_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
      .drv_state_i(drv_state_i), .cmd_push_o(cmd_push_o), .cmd_rw_o(cmd_rw_o),
      .tx_push_o(tx_push_o), .tx_byte_o(tx_byte_o), .rx_pop_o(rx_pop_o),
      .rx_byte_i(rx_byte_i), .dbg_state_o(dbg_state_o)
   );

   always @(posedge clk) begin
      if (cmd_push_o === 1'b1) cmd_cnt <= cmd_cnt + 1;
      if (tx_push_o === 1'b1) tx_cnt <= tx_cnt + 1;
      if (rx_pop_o === 1'b1) pop_cnt <= pop_cnt + 1;
      if (done_o !== 2'b00) done_cnt <= done_cnt + 1;
   end

   task automatic set_client(input int c, input logic rw, input logic [6:0] addr, input logic [7:0] wd);
      rw_i[c] = rw;
      if (c == 0) begin
         addr_i[6:0] = addr;
         wdata_i[7:0] = wd;
      end else begin
         addr_i[13:7] = addr;
         wdata_i[15:8] = wd;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_i = 2'b00;
      drv_state_i = 4'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Runs one granted transaction: checks both pushes, models a driver frame of
   // 'busy' cycles, returns the rx byte one cycle after the pop, checks the response.
   task automatic serve(input int c, input logic [7:0] exp0, input logic [7:0] exp1,
                        input bit rd, input logic [7:0] rx, input int busy, input bit drop);
      int c0, t0, p0;
      bit seen, pop_prev;
      logic [1:0] exp_done;
      c0 = cmd_cnt; t0 = tx_cnt; p0 = pop_cnt;
      exp_done = (c == 1) ? 2'b10 : 2'b01;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (cmd_push_o === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         fails++;
         $display("FAIL grant_wait: cmd_push_o stayed 0 for 40 cycles, required 1");
         return;
      end
      checks++;
      if ({tx_push_o, tx_byte_o, cmd_rw_o} !== {1'b1, exp0, 2'b01}) begin
         fails++;
         $display("FAIL push0: tx_push=%b tx_byte=%h cmd_rw=%b, required 1 %h 01",
                  tx_push_o, tx_byte_o, cmd_rw_o, exp0);
      end
      @(negedge clk);
      checks++;
      if (rd && {cmd_push_o, cmd_rw_o, tx_push_o} !== {1'b1, 2'b10, 1'b0}) begin
         fails++;
         $display("FAIL push1_read: cmd_push=%b cmd_rw=%b tx_push=%b, required 1 10 0",
                  cmd_push_o, cmd_rw_o, tx_push_o);
      end else if (!rd && {cmd_push_o, cmd_rw_o, tx_push_o, tx_byte_o} !== {1'b1, 2'b01, 1'b1, exp1}) begin
         fails++;
         $display("FAIL push1_write: cmd_push=%b cmd_rw=%b tx_push=%b tx_byte=%h, required 1 01 1 %h",
                  cmd_push_o, cmd_rw_o, tx_push_o, tx_byte_o, exp1);
      end
      @(negedge clk);
      drv_state_i = 4'h3;
      if (drop) req_i[c] = 1'b0;
      repeat (busy) @(negedge clk);
      checks++;
      if (done_o !== 2'b00) begin
         fails++;
         $display("FAIL early_done: done_o=%b while driver busy, required 00", done_o);
      end
      drv_state_i = 4'h0;
      rx_byte_i = ~rx;
      seen = 0;
      pop_prev = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (pop_prev) rx_byte_i = rx;
         pop_prev = (rx_pop_o === 1'b1);
         if (done_o !== 2'b00) seen = 1;
      end
      checks++;
      if (!seen || done_o !== exp_done || err_o !== 1'b0) begin
         fails++;
         $display("FAIL done: done_o=%b err_o=%b, required %b 0", done_o, err_o, exp_done);
      end
      if (rd) begin
         checks++;
         if (rdata_o !== rx) begin
            fails++;
            $display("FAIL rdata: rdata_o=%h, required %h", rdata_o, rx);
         end
      end
      req_i[c] = 1'b0;
      checks++;
      if (cmd_cnt - c0 != 2 || tx_cnt - t0 != (rd ? 1 : 2) || pop_cnt - p0 != (rd ? 1 : 0)) begin
         fails++;
         $display("FAIL push_counts: cmd=%0d tx=%0d pop=%0d, required 2 %0d %0d",
                  cmd_cnt - c0, tx_cnt - t0, pop_cnt - p0, rd ? 1 : 2, rd ? 1 : 0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_i = 2'b00; rw_i = 2'b00; addr_i = '0; wdata_i = '0; rx_byte_i = 8'h00;
      drv_state_i = 4'h6;
      repeat (2) @(negedge clk);
      checks++;
      if ({done_o, rdata_o, err_o, cmd_push_o, cmd_rw_o, tx_push_o, tx_byte_o, rx_pop_o} !== 24'h0) begin
         fails++;
         $display("FAIL reset_outputs: %h, required 000000",
                  {done_o, rdata_o, err_o, cmd_push_o, cmd_rw_o, tx_push_o, tx_byte_o, rx_pop_o});
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (dbg_state_o !== 4'd0) begin
         fails++;
         $display("FAIL init_hold: state=%0d while driver busy, required 0", dbg_state_o);
      end
      drv_state_i = 4'h0;
      @(negedge clk);
      checks++;
      if (dbg_state_o !== 4'd1) begin
         fails++;
         $display("FAIL init_exit: state=%0d, required 1", dbg_state_o);
      end
   endtask

   task automatic test_write();
      set_client(0, 1'b0, 7'h12, 8'hA5);
      req_i[0] = 1'b1;
      serve(0, 8'h12, 8'hA5, 1'b0, 8'h00, 6, 1'b0);
   endtask

   task automatic test_read();
      set_client(1, 1'b1, 7'h05, 8'h00);
      req_i[1] = 1'b1;
      serve(1, 8'h85, 8'h00, 1'b1, 8'h3C, 4, 1'b0);
      // a following write must leave the last read data in place
      set_client(0, 1'b0, 7'h7F, 8'h01);
      req_i[0] = 1'b1;
      serve(0, 8'h7F, 8'h01, 1'b0, 8'h00, 3, 1'b0);
      checks++;
      if (rdata_o !== 8'h3C) begin
         fails++;
         $display("FAIL rdata_hold: rdata_o=%h, required 3c", rdata_o);
      end
   endtask

   task automatic test_both();
      logic [1:0] c;
      do_reset();
      set_client(0, 1'b0, 7'h01, 8'h11);
      set_client(1, 1'b0, 7'h02, 8'h22);
      exp_q = {2'd0, 2'd1, 2'd0, 2'd1};
      for (int pair = 0; pair < 2; pair++) begin
         req_i = 2'b11;
         for (int k = 0; k < 2; k++) begin
            c = exp_q.pop_front();
            if (c == 2'd0) serve(0, 8'h01, 8'h11, 1'b0, 8'h00, 2, 1'b0);
            else           serve(1, 8'h02, 8'h22, 1'b0, 8'h00, 2, 1'b0);
         end
      end
   endtask

   task automatic test_reset_mid();
      int c0, d0;
      bit seen;
      set_client(0, 1'b0, 7'h33, 8'h44);
      req_i[0] = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (cmd_push_o === 1'b1) seen = 1;
      end
      @(negedge clk);
      @(negedge clk);
      drv_state_i = 4'h4;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({done_o, rdata_o, err_o, cmd_push_o, cmd_rw_o, tx_push_o, tx_byte_o, rx_pop_o, dbg_state_o} !== 28'h0) begin
         fails++;
         $display("FAIL midreset_outputs: %h, required 0000000",
                  {done_o, rdata_o, err_o, cmd_push_o, cmd_rw_o, tx_push_o, tx_byte_o, rx_pop_o, dbg_state_o});
      end
      rst_n = 1'b1;
      c0 = cmd_cnt; d0 = done_cnt;
      repeat (8) @(negedge clk);
      checks++;
      if (cmd_cnt != c0 || done_cnt != d0 || dbg_state_o !== 4'd0) begin
         fails++;
         $display("FAIL midreset_hold: cmd=%0d done=%0d state=%0d, required 0 0 0",
                  cmd_cnt - c0, done_cnt - d0, dbg_state_o);
      end
      drv_state_i = 4'h0;
      serve(0, 8'h33, 8'h44, 1'b0, 8'h00, 3, 1'b0);
   endtask

   task automatic test_drop();
      int c0;
      set_client(0, 1'b0, 7'h10, 8'h5A);
      req_i[0] = 1'b1;
      serve(0, 8'h10, 8'h5A, 1'b0, 8'h00, 5, 1'b1);
      c0 = cmd_cnt;
      repeat (5) @(negedge clk);
      checks++;
      if (cmd_cnt != c0 || dbg_state_o !== 4'd1) begin
         fails++;
         $display("FAIL drop_after: extra cmd=%0d state=%0d, required 0 1", cmd_cnt - c0, dbg_state_o);
      end
   endtask

`ifdef LENS_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      bit seen;
      set_client(0, 1'b0, 7'h12, 8'hA5);
      req_i[0] = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (cmd_push_o === 1'b1) seen = 1;
      end
      @(negedge clk);
      drv_state_i = 4'h7;
      // counter is 0 on the first WAIT cycle (n=1), hits 200 at n=201, RESP at n=202
      n = 0;
      seen = 0;
      while (n < 400 && !seen) begin
         @(negedge clk);
         n++;
         if (done_o !== 2'b00) seen = 1;
      end
      checks++;
      if (!seen || n != 202 || done_o !== 2'b01 || err_o !== 1'b1) begin
         fails++;
         $display("FAIL timeout: cycle=%0d done_o=%b err_o=%b, required 202 01 1", n, done_o, err_o);
      end
      req_i[0] = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (dbg_state_o !== 4'd0) begin
         fails++;
         $display("FAIL timeout_init: state=%0d, required 0", dbg_state_o);
      end
      drv_state_i = 4'h0;
      @(negedge clk);
      checks++;
      if (dbg_state_o !== 4'd1) begin
         fails++;
         $display("FAIL timeout_recover: state=%0d, required 1", dbg_state_o);
      end
      req_i[0] = 1'b1;
      serve(0, 8'h12, 8'hA5, 1'b0, 8'h00, 3, 1'b0);
   endtask
`else
   task automatic test_timeout();
      // without the timeout a long frame simply completes late and error-free
      set_client(0, 1'b0, 7'h12, 8'hA5);
      req_i[0] = 1'b1;
      serve(0, 8'h12, 8'hA5, 1'b0, 8'h00, 300, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_reset_mid();
      test_both();
      test_drop();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
